// File: rtl/addatone_pkg.sv
// Shared types and width helpers for the additive-oscillator phase engine.
package addatone_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    READ,
    HOLD
  } state_t;

  // Increment register is wide enough that freq*(h+1) never wraps.
  function automatic int inc_width(input int freq_w, input int harm_bits);
    return freq_w + harm_bits + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/harmonic_phase_accumulator_phase_ram.sv
// Single-port synchronous phase RAM, write-first, 1-cycle read latency.
module phase_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/harmonic_phase_accumulator.sv
// Per-sample sweep over harmonics 0..n-1: phase[h] += freq*(h+1), streamed out over valid/ready.
//
// state | meaning
// CLEAR | zeroing phase RAM after reset, one address per cycle
// IDLE  | waiting for sample_start; RAM address parked at 0
// READ  | RAM data for addr valid; compute and write back new phase
// HOLD  | phase presented, waiting for phase_ready
module harmonic_phase_accumulator
  import addatone_pkg::*;
#(
  parameter int PHASE_WIDTH   = 16,
  parameter int FREQ_WIDTH    = 16,
  parameter int NUM_HARMONICS = 64,
  parameter int HARM_BITS     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_start,
  input  logic [FREQ_WIDTH-1:0]  frequency,
  input  logic [HARM_BITS:0]     active_harmonics,
  input  logic                   hard_sync,
  output logic                   phase_valid,
  input  logic                   phase_ready,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic [HARM_BITS-1:0]   harmonic,
  output logic                   aliased,
  output logic                   sweep_done,
  output logic                   busy,
  output logic                   overrun
);

  localparam int INC_W  = inc_width(FREQ_WIDTH, HARM_BITS);
  localparam int CMP_W  = max_int(INC_W, PHASE_WIDTH);
  localparam int RAM_AW = addr_width(NUM_HARMONICS);
  localparam logic [HARM_BITS:0]   N_MAX  = (HARM_BITS+1)'(NUM_HARMONICS);
  localparam logic [HARM_BITS:0]   N_ONE  = (HARM_BITS+1)'(1);
  localparam logic [HARM_BITS-1:0] A_LAST = HARM_BITS'(NUM_HARMONICS - 1);
  localparam logic [HARM_BITS-1:0] A_ONE  = HARM_BITS'(1);

  state_t                 state, state_d;
  logic [HARM_BITS-1:0]   addr, addr_d, addr_next;
  logic [INC_W-1:0]       inc, inc_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic [HARM_BITS:0]     n_q, n_d, n_clamp;
  logic                   sync_now, sync_now_d, sync_pending, sync_pending_d;
  logic                   valid_d, aliased_d, done_d, busy_d, overrun_d;
  logic [PHASE_WIDTH-1:0] phase_d, phase_new;
  logic [HARM_BITS-1:0]   harmonic_d;
  logic                   inc_alias, is_last;

  logic                   ram_we;
  logic [RAM_AW-1:0]      ram_addr;
  logic [PHASE_WIDTH-1:0] ram_wdata, ram_rdata;

  phase_ram #(
    .DEPTH (NUM_HARMONICS),
    .WIDTH (PHASE_WIDTH),
    .AW    (RAM_AW)
  ) u_phase_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign addr_next = addr + A_ONE;
  assign is_last   = ({1'b0, addr} == (n_q - N_ONE));
  assign phase_new = sync_now ? '0 : (ram_rdata + PHASE_WIDTH'(inc));
  assign inc_alias = ((CMP_W'(inc)) >> (PHASE_WIDTH - 1)) != '0;

  always_comb begin
    n_clamp = active_harmonics;
    if (active_harmonics == '0)
      n_clamp = N_ONE;
    else if (active_harmonics > N_MAX)
      n_clamp = N_MAX;
  end

  always_comb begin
    state_d        = state;
    addr_d         = addr;
    inc_d          = inc;
    freq_d         = freq_q;
    n_d            = n_q;
    sync_now_d     = sync_now;
    sync_pending_d = sync_pending | hard_sync;
    valid_d        = phase_valid;
    phase_d        = phase;
    harmonic_d     = harmonic;
    aliased_d      = aliased;
    done_d         = 1'b0;
    overrun_d      = sample_start & (state != IDLE);
    ram_we         = 1'b0;
    ram_wdata      = phase_new;
    ram_addr       = RAM_AW'(addr);

    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = '0;
        if (addr == A_LAST) begin
          addr_d  = '0;
          state_d = IDLE;
        end else begin
          addr_d = addr_next;
        end
      end
      IDLE: begin
        ram_addr = '0;
        if (sample_start) begin
          freq_d         = frequency;
          n_d            = n_clamp;
          inc_d          = INC_W'(frequency);
          addr_d         = '0;
          sync_now_d     = sync_pending | hard_sync;
          sync_pending_d = 1'b0;
          state_d        = READ;
        end
      end
      READ: begin
        ram_we     = 1'b1;
        phase_d    = phase_new;
        harmonic_d = addr;
        aliased_d  = inc_alias;
        valid_d    = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        // Keep the next harmonic's read in flight so READ sees valid data.
        ram_addr = RAM_AW'(addr_next);
        if (phase_ready) begin
          valid_d = 1'b0;
          if (is_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_next;
            inc_d   = inc + INC_W'(freq_q);
            state_d = READ;
          end
        end
      end
      default: state_d = CLEAR;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CLEAR;
      addr         <= '0;
      inc          <= '0;
      freq_q       <= '0;
      n_q          <= '0;
      sync_now     <= 1'b0;
      sync_pending <= 1'b0;
      phase_valid  <= 1'b0;
      phase        <= '0;
      harmonic     <= '0;
      aliased      <= 1'b0;
      sweep_done   <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      addr         <= addr_d;
      inc          <= inc_d;
      freq_q       <= freq_d;
      n_q          <= n_d;
      sync_now     <= sync_now_d;
      sync_pending <= sync_pending_d;
      phase_valid  <= valid_d;
      phase        <= phase_d;
      harmonic     <= harmonic_d;
      aliased      <= aliased_d;
      sweep_done   <= done_d;
      busy         <= busy_d;
      overrun      <= overrun_d;
    end
  end

endmodule

// File: tb/tb_harmonic_phase_accumulator.sv
// Randomised and directed bench for harmonic_phase_accumulator against a per-harmonic phase model.
module tb_harmonic_phase_accumulator;

  localparam int NH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_start = 1'b0;
  logic [15:0] frequency = '0;
  logic [8:0]  active_harmonics = '0;
  logic        hard_sync = 1'b0;
  logic        phase_ready = 1'b0;
  logic        phase_valid;
  logic [15:0] phase;
  logic [7:0]  harmonic;
  logic        aliased, sweep_done, busy, overrun;

  harmonic_phase_accumulator dut (
    .clock            (clock),
    .reset            (reset),
    .sample_start     (sample_start),
    .frequency        (frequency),
    .active_harmonics (active_harmonics),
    .hard_sync        (hard_sync),
    .phase_valid      (phase_valid),
    .phase_ready      (phase_ready),
    .phase            (phase),
    .harmonic         (harmonic),
    .aliased          (aliased),
    .sweep_done       (sweep_done),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ph;
    int          h;
    bit          al;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        log_q[$];
  int          hs_cyc[$];
  logic [15:0] mphase [NH];
  bit          pending;
  int exp_done, exp_ovr, done_seen, ovr_seen, stall_seen, start_cyc;
  int total, bad;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_rec(input string name, input logic [15:0] ph, input int h, input bit al,
                                  input logic [15:0] eph, input int eh, input bit eal);
    total++;
    if (ph !== eph || h != eh || al != eal) begin
      bad++;
      $display("FAIL %s: got phase=%h harm=%0d alias=%0b want phase=%h harm=%0d alias=%0b",
               name, ph, h, al, eph, eh, eal);
    end
  endfunction

  // Model: a whole sweep's expected outputs are computed at the moment it is started.
  function automatic void begin_sweep(input logic [15:0] f, input int ah, input bit hs);
    int n;
    bit sn;
    int unsigned incv;
    logic [15:0] nv;
    rec_t r;
    n = ah;
    if (n < 1) n = 1;
    if (n > NH) n = NH;
    sn = pending | hs;
    pending = 0;
    for (int h = 0; h < n; h++) begin
      incv = int'(f) * (h + 1);
      nv = sn ? 16'h0 : 16'((int'(mphase[h]) + incv) % 65536);
      mphase[h] = nv;
      r.ph = nv;
      r.h  = h;
      r.al = (incv >= 32768);
      exp_q.push_back(r);
    end
    exp_done++;
  endfunction

  initial begin
    rec_t r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (phase_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", phase_valid, 0);
          end else begin
            chk_rec("phase_out", phase, int'(harmonic), aliased, exp_q[0].ph, exp_q[0].h, exp_q[0].al);
            if (phase_ready) begin
              r.ph = phase;
              r.h  = int'(harmonic);
              r.al = aliased;
              log_q.push_back(r);
              hs_cyc.push_back(cyc);
              void'(exp_q.pop_front());
            end else begin
              stall_seen++;
            end
          end
        end
        if (sweep_done) done_seen++;
        if (overrun) ovr_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    int rel, k;
    reset = 1; sample_start = 0; hard_sync = 0; phase_ready = 0;
    if (exp_q.size() != 0) exp_done--;
    exp_q.delete();
    pending = 0;
    foreach (mphase[i]) mphase[i] = '0;
    tick();
    chk("valid_after_reset", phase_valid, 0);
    tick();
    chk("reset_outputs", {phase_valid, phase, harmonic, aliased, sweep_done, busy, overrun}, 0);
    reset = 0;
    rel = cyc;
    tick();
    chk("busy_in_clear", busy, 1);
    sample_start = 1;
    exp_ovr++;
    tick();
    sample_start = 0;
    k = 0;
    while (busy && k < 4 * NH) begin
      tick();
      k++;
    end
    chk("clear_cycles", cyc - rel, NH);
  endtask

  task automatic run_sweep(input logic [15:0] f, input int ah, input bit hs, input int ready_pct,
                           input int stall_h, input int stall_len, input int ovr_at, input int hs_at,
                           input int rnd_pct);
    int k, stalled;
    bit ss, hy;
    log_q.delete();
    hs_cyc.delete();
    stall_seen = 0;
    frequency = f;
    active_harmonics = 9'(ah);
    hard_sync = hs;
    sample_start = 1;
    phase_ready = 1;
    start_cyc = cyc;
    begin_sweep(f, ah, hs);
    tick();
    sample_start = 0;
    hard_sync = 0;
    k = 0;
    stalled = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      ss = (k == ovr_at) || (rnd_pct > 0 && $urandom_range(99) < rnd_pct);
      hy = (k == hs_at) || (rnd_pct > 0 && $urandom_range(99) < rnd_pct);
      if (ss) exp_ovr++;
      if (hy) pending = 1;
      if (stall_h >= 0 && log_q.size() == stall_h && stalled < stall_len) begin
        phase_ready = 0;
        stalled++;
      end else begin
        phase_ready = ($urandom_range(99) < ready_pct);
      end
      sample_start = ss;
      hard_sync = hy;
      frequency = 16'($urandom);
      active_harmonics = 9'($urandom);
      tick();
      sample_start = 0;
      hard_sync = 0;
      k++;
    end
    chk("sweep_drain", exp_q.size(), 0);
    exp_q.delete();
    tick();
    chk("sweep_done_count", done_seen, exp_done);
    chk("overrun_count", ovr_seen, exp_ovr);
  endtask

  task automatic chk_log(input int idx, input logic [15:0] ph, input int h, input bit al);
    if (idx < log_q.size())
      chk_rec("log_entry", log_q[idx].ph, log_q[idx].h, log_q[idx].al, ph, h, al);
    else
      chk("log_len", log_q.size(), idx + 1);
  endtask

  initial begin
    total = 0; bad = 0; exp_done = 0; exp_ovr = 0; done_seen = 0; ovr_seen = 0; pending = 0;
    do_reset();

    // freq 0, four harmonics
    run_sweep(16'h0000, 4, 0, 100, -1, 0, -1, -1, 0);
    chk("n4_len", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_log(i, 16'h0000, i, 0);

    // two sweeps at 0x0100 with latency/throughput
    run_sweep(16'h0100, 3, 0, 100, -1, 0, -1, -1, 0);
    chk_log(0, 16'h0100, 0, 0); chk_log(1, 16'h0200, 1, 0); chk_log(2, 16'h0300, 2, 0);
    if (hs_cyc.size() == 3) begin
      chk("first_latency", hs_cyc[0] - start_cyc, 2);
      for (int i = 1; i < 3; i++) chk("spacing", hs_cyc[i] - hs_cyc[i-1], 2);
    end else begin
      chk("hs_count", hs_cyc.size(), 3);
    end
    run_sweep(16'h0100, 3, 0, 100, -1, 0, -1, -1, 0);
    chk_log(0, 16'h0200, 0, 0); chk_log(1, 16'h0400, 1, 0); chk_log(2, 16'h0600, 2, 0);

    // wrap and alias from a cleared RAM
    do_reset();
    run_sweep(16'h6000, 3, 0, 100, -1, 0, -1, -1, 0);
    chk_log(0, 16'h6000, 0, 0); chk_log(1, 16'hC000, 1, 1); chk_log(2, 16'h2000, 2, 1);

    // stall on h1 with an overrun during the stall
    run_sweep(16'h0010, 3, 0, 100, 1, 6, 3, -1, 0);
    chk("stall_cycles", stall_seen, 5);
    chk("stall_len", log_q.size(), 3);

    // hard_sync mid-sweep applies to the following sweep only
    run_sweep(16'h0300, 4, 0, 100, -1, 0, -1, 2, 0);
    run_sweep(16'h0300, 4, 0, 100, -1, 0, -1, -1, 0);
    for (int i = 0; i < 4; i++) chk_log(i, 16'h0000, i, 0);
    run_sweep(16'h0300, 4, 0, 100, -1, 0, -1, -1, 0);
    chk_log(0, 16'h0300, 0, 0); chk_log(1, 16'h0600, 1, 0);
    chk_log(2, 16'h0900, 2, 0); chk_log(3, 16'h0C00, 3, 0);

    // harmonic-count clamping
    run_sweep(16'h0001, 0, 0, 100, -1, 0, -1, -1, 0);
    chk("clamp_low_len", log_q.size(), 1);
    run_sweep(16'h0001, NH + 5, 0, 100, -1, 0, -1, -1, 0);
    chk("clamp_high_len", log_q.size(), NH);
    if (log_q.size() == NH) chk("clamp_high_last", log_q[NH-1].h, NH - 1);

    // reset in the middle of a stalled sweep
    frequency = 16'h1234; active_harmonics = 9'd10; phase_ready = 0; sample_start = 1;
    begin_sweep(16'h1234, 10, 0);
    tick(); sample_start = 0;
    tick(); tick(); tick();
    do_reset();
    run_sweep(16'h1000, 2, 0, 100, -1, 0, -1, -1, 0);
    chk_log(0, 16'h1000, 0, 0); chk_log(1, 16'h2000, 1, 0);

    // randomised sweeps
    for (int s = 0; s < 30; s++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(9) == 0) begin
          hard_sync = 1;
          pending = 1;
        end
        tick();
        hard_sync = 0;
      end
      run_sweep(16'($urandom), $urandom_range(0, 70), ($urandom_range(7) == 0), 70, -1, 0, -1, -1, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
